// File: rtl/audio_sample_queue_pkg.sv
// Shared constants, FSM state type and debug view for the audio sample queue.
// The window (TAPS) must stay shorter than the ring (DEPTH) so the write slot never lands inside it.
package audio_sample_queue_pkg;

  localparam int DEPTH  = 1024;
  localparam int TAPS   = 1021;
  localparam int SMPL_W = 16;
  localparam int WORD_W = 2 * SMPL_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(TAPS + 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    SEQ  = 2'd2
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] fill;
    logic             pending;
  } dbg_t;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Oldest slot of a window whose newest sample sits just below p.
  function automatic logic [AW-1:0] ptr_back(input logic [AW-1:0] p);
    return (p >= AW'(TAPS)) ? p - AW'(TAPS) : p + AW'(DEPTH - TAPS);
  endfunction

endpackage

// File: rtl/audio_sample_queue_if.sv
// Codec-side sample input and window readout of the audio sample queue.
// valid is a level: one stereo sample is taken on its rising edge; readout has no back-pressure.
interface audio_sample_queue_if;
  import audio_sample_queue_pkg::*;

  logic                     valid;
  logic signed [SMPL_W-1:0] lft_in;
  logic signed [SMPL_W-1:0] rht_in;
  logic signed [SMPL_W-1:0] lft_smpl;
  logic signed [SMPL_W-1:0] rht_smpl;
  logic                     sequencing;
  logic                     seq_first;
  logic                     seq_last;
  logic                     full;
  dbg_t                     dbg;

  modport master (
    output valid, lft_in, rht_in,
    input  lft_smpl, rht_smpl, sequencing, seq_first, seq_last, full, dbg
  );

  modport slave (
    input  valid, lft_in, rht_in,
    output lft_smpl, rht_smpl, sequencing, seq_first, seq_last, full, dbg
  );

endinterface

// File: rtl/dualport_ram.sv
// DEPTH x WORD_W sample ring: one synchronous write port, one synchronous read port, no reset.
// The read register holds its value while re is low.
module dualport_ram
  import audio_sample_queue_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [WORD_W-1:0] wd,
  input  logic              re,
  input  logic [AW-1:0]     ra,
  output logic [WORD_W-1:0] rq
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rq <= mem[ra];
  end

endmodule

// File: rtl/audio_sample_queue.sv
// Stores stereo samples in a ring and, after each new sample, streams the last TAPS
// samples oldest-to-newest. One extra sample arriving mid-window queues one follow-on window.
module audio_sample_queue
  import audio_sample_queue_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  audio_sample_queue_if.slave bus
);

  state_t            state;
  logic              valid_q;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  fill;
  logic [CNT_W-1:0]  rd_cnt;
  logic              pending;
  logic              rd_seen;
  logic              sequencing;
  logic              seq_first;
  logic              seq_last;
  logic [WORD_W-1:0] rd_q;

  logic          new_smpl;
  logic          rd_en;
  logic          last_rd;
  logic [AW-1:0] wr_nxt;

  assign new_smpl = bus.valid & ~valid_q;
  assign rd_en    = (state == SEQ);
  assign last_rd  = rd_en && (rd_cnt == CNT_W'(TAPS - 1));
  assign wr_nxt   = new_smpl ? ptr_inc(wr_ptr) : wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      valid_q    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      rd_cnt     <= '0;
      pending    <= 1'b0;
      rd_seen    <= 1'b0;
      sequencing <= 1'b0;
      seq_first  <= 1'b0;
      seq_last   <= 1'b0;
    end else begin
      valid_q    <= bus.valid;
      sequencing <= rd_en;
      seq_first  <= rd_en && (rd_cnt == '0);
      seq_last   <= last_rd;
      if (rd_en) rd_seen <= 1'b1;

      if (new_smpl) begin
        wr_ptr <= wr_nxt;
        if (fill != CNT_W'(TAPS)) fill <= fill + 1'b1;
      end

      case (state)
        FILL: begin
          if (new_smpl && (fill == CNT_W'(TAPS - 1))) begin
            state  <= SEQ;
            rd_ptr <= ptr_back(wr_nxt);
            rd_cnt <= '0;
          end
        end
        WAIT: begin
          if (new_smpl) begin
            state  <= SEQ;
            rd_ptr <= ptr_back(wr_nxt);
            rd_cnt <= '0;
          end
        end
        SEQ: begin
          rd_ptr <= ptr_inc(rd_ptr);
          rd_cnt <= rd_cnt + 1'b1;
          // A sample landing on the last read cycle counts as pending too.
          if (last_rd) begin
            if (pending || new_smpl) begin
              rd_ptr  <= ptr_back(wr_nxt);
              rd_cnt  <= '0;
              pending <= 1'b0;
            end else begin
              state <= WAIT;
            end
          end else if (new_smpl) begin
            pending <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  dualport_ram u_ram (
    .clk (clk),
    .we  (new_smpl),
    .wa  (wr_ptr),
    .wd  ({bus.lft_in, bus.rht_in}),
    .re  (rd_en),
    .ra  (rd_ptr),
    .rq  (rd_q)
  );

  // RAM has no reset, so outputs are masked to zero until the first read after reset.
  assign bus.lft_smpl   = rd_seen ? $signed(rd_q[WORD_W-1:SMPL_W]) : '0;
  assign bus.rht_smpl   = rd_seen ? $signed(rd_q[SMPL_W-1:0]) : '0;
  assign bus.sequencing = sequencing;
  assign bus.seq_first  = seq_first;
  assign bus.seq_last   = seq_last;
  assign bus.full       = (fill == CNT_W'(TAPS));
  assign bus.dbg        = '{state: state, wr_ptr: wr_ptr, rd_ptr: rd_ptr, fill: fill, pending: pending};

endmodule

// File: tb/tb_audio_sample_queue.sv
// Bench for audio_sample_queue: edge-detect vector table, then fill, wrap, pending and
// mid-window reset sequences checked through a window scoreboard.
module tb_audio_sample_queue;
  import audio_sample_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  audio_sample_queue_if bus();

  audio_sample_queue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int passed = 0;
  int cyc = 0;

  // {first, last, left, right}
  logic [33:0] exp_q[$];
  logic [33:0] act_q[$];
  int          act_cyc[$];

  typedef struct {
    logic valid;
    int   exp_wr;
  } vec_t;
  vec_t vecs[10];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.sequencing === 1'b1) begin
      act_q.push_back({bus.seq_first, bus.seq_last, bus.lft_smpl, bus.rht_smpl});
      act_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n);
    bus.lft_in = 16'(n);
    bus.rht_in = 16'(-n);
    bus.valid  = 1'b1;
    tick();
    bus.valid  = 1'b0;
    tick();
  endtask

  task automatic push_window(input int a, input int b);
    for (int n = a; n <= b; n++) begin
      logic [15:0] l;
      logic [15:0] r;
      l = 16'(n);
      r = 16'(-n);
      exp_q.push_back({n == a, n == b, l, r});
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((bus.dbg.state == SEQ || bus.sequencing) && k < 4000) begin
      tick();
      k++;
    end
    check({name, "_idle_timeout"}, int'(k >= 4000), 0);
  endtask

  task automatic check_windows(input string name);
    int mism;
    int gaps;
    mism = 0;
    gaps = 0;
    check({name, "_len"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (act_q[i] !== exp_q[i]) mism++;
    for (int i = 1; i < act_cyc.size(); i++)
      if (act_cyc[i] != act_cyc[i-1] + 1) gaps++;
    check({name, "_data_mismatches"}, mism, 0);
    check({name, "_gaps"}, gaps, 0);
    act_q.delete();
    act_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.valid  = 1'b0;
    bus.lft_in = '0;
    bus.rht_in = '0;
    vecs[0] = '{1'b1, 2}; vecs[1] = '{1'b1, 2}; vecs[2] = '{1'b0, 2};
    vecs[3] = '{1'b1, 3}; vecs[4] = '{1'b0, 3}; vecs[5] = '{1'b0, 3};
    vecs[6] = '{1'b1, 4}; vecs[7] = '{1'b1, 4}; vecs[8] = '{1'b0, 4};
    vecs[9] = '{1'b1, 5};

    do_reset();
    check("rst_sequencing", int'(bus.sequencing), 0);
    check("rst_full", int'(bus.full), 0);
    check("rst_lft", int'(bus.lft_smpl), 0);
    check("rst_rht", int'(bus.rht_smpl), 0);
    check("rst_wr_ptr", int'(bus.dbg.wr_ptr), 0);
    check("rst_state", int'(bus.dbg.state), int'(FILL));

    // Held valid level produces a single write.
    bus.lft_in = 16'h1234;
    bus.rht_in = 16'hEDCB;
    bus.valid  = 1'b1;
    repeat (50) tick();
    bus.valid = 1'b0;
    tick();
    check("held_valid_wr_ptr", int'(bus.dbg.wr_ptr), 1);
    check("held_valid_fill", int'(bus.dbg.fill), 1);
    check("held_valid_no_readout", act_q.size(), 0);

    for (int i = 0; i < 10; i++) begin
      bus.valid = vecs[i].valid;
      tick();
      check($sformatf("vec%0d_wr_ptr", i), int'(bus.dbg.wr_ptr), vecs[i].exp_wr);
      check($sformatf("vec%0d_fill", i), int'(bus.dbg.fill), vecs[i].exp_wr);
      check($sformatf("vec%0d_seq", i), int'(bus.sequencing), 0);
    end
    bus.valid = 1'b0;
    tick();

    // Fill from empty, then a window plus a pending follow-on that wraps the ring.
    do_reset();
    for (int n = 0; n < TAPS - 1; n++) send_frame(n);
    check("fill_no_readout", act_q.size(), 0);
    check("fill_not_full", int'(bus.full), 0);
    bus.lft_in = 16'(TAPS - 1);
    bus.rht_in = 16'(-(TAPS - 1));
    bus.valid  = 1'b1;
    tick();
    check("fill_state_seq", int'(bus.dbg.state), int'(SEQ));
    check("fill_seq_T1", int'(bus.sequencing), 0);
    check("fill_full", int'(bus.full), 1);
    bus.valid = 1'b0;
    tick();
    check("fill_seq_T2", int'(bus.sequencing), 1);
    check("fill_first_T2", int'(bus.seq_first), 1);
    check("fill_lft_T2", int'(bus.lft_smpl), 0);
    push_window(0, 1020);
    for (int n = 1021; n <= 1099; n++) send_frame(n);
    check("wrap_pending", int'(bus.dbg.pending), 1);
    push_window(79, 1099);
    wait_idle("fill_wrap");
    check_windows("win_fill_wrap");
    check("wrap_state_wait", int'(bus.dbg.state), int'(WAIT));

    // New edge 500 cycles into a window queues exactly one follow-on window.
    send_frame(1100);
    repeat (498) tick();
    send_frame(1101);
    check("mid_pending", int'(bus.dbg.pending), 1);
    push_window(80, 1100);
    push_window(81, 1101);
    wait_idle("pending");
    check_windows("win_pending");
    check("hold_lft", int'(bus.lft_smpl), 1101);
    check("hold_rht", int'(bus.rht_smpl), -1101);

    // Reset 300 cycles into a window.
    send_frame(1102);
    repeat (298) tick();
    check("pre_rst_seq", int'(bus.sequencing), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_seq", int'(bus.sequencing), 0);
    check("midrst_full", int'(bus.full), 0);
    check("midrst_state", int'(bus.dbg.state), int'(FILL));
    check("midrst_lft", int'(bus.lft_smpl), 0);
    tick();
    rst_n = 1'b1;
    act_q.delete();
    act_cyc.delete();
    tick();
    for (int n = 2000; n < 2000 + TAPS - 1; n++) send_frame(n);
    check("refill_no_readout", act_q.size(), 0);
    check("refill_lft_zero", int'(bus.lft_smpl), 0);
    check("refill_not_full", int'(bus.full), 0);
    send_frame(2000 + TAPS - 1);
    push_window(2000, 2000 + TAPS - 1);
    wait_idle("refill");
    check_windows("win_refill");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
